// File: rtl/result_mem_pkg.sv
// Frame geometry and writer FSM state shared by the result-memory write and display read paths.
package result_mem_pkg;

  localparam int unsigned FRAME_W      = 640;
  localparam int unsigned FRAME_H      = 480;
  localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int unsigned PIX_ADDR_W   = 19;
  localparam int unsigned PIX_DATA_W   = 8;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } wr_state_t;

endpackage

// File: rtl/result_mem_writer_if.sv
// Pixel-stream input and memory write port of the result memory writer.
interface result_mem_writer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
) ();

  logic              start;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wait;
  logic              busy;
  logic              frame_done;

  // Driven side: processing datapath plus memory.
  modport master (
    output start, pix_valid, pix_data, mem_wait,
    input  pix_ready, mem_we, mem_addr, mem_wdata, busy, frame_done
  );

  // Writer side.
  modport slave (
    input  start, pix_valid, pix_data, mem_wait,
    output pix_ready, mem_we, mem_addr, mem_wdata, busy, frame_done
  );

endinterface

// File: rtl/pix_fifo.sv
// Small synchronous FIFO buffering pixels between the input handshake and the memory write register.
module pix_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

endmodule

// File: rtl/result_mem_writer.sv
// Writes one frame of processed pixels into the result memory in raster order, then pulses
// frame_done once the last write has been committed.
module result_mem_writer
  import result_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = FRAME_W,
  parameter int unsigned HEIGHT     = FRAME_H,
  parameter int unsigned ADDR_W     = PIX_ADDR_W,
  parameter int unsigned DATA_W     = PIX_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  result_mem_writer_if.slave bus
);

  localparam logic [ADDR_W-1:0] FramePix = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] LastAddr = FramePix - ADDR_W'(1);

  wr_state_t         state_q;
  logic [ADDR_W-1:0] in_cnt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              frame_done_q;

  logic              fifo_full, fifo_empty, fifo_clr;
  logic [DATA_W-1:0] fifo_rdata;
  logic              pix_ready, push, pop, reg_free, commit, last_commit;

  assign fifo_clr    = (state_q == StIdle) && bus.start;
  assign pix_ready   = (state_q == StWrite) && !fifo_full && (in_cnt_q < FramePix);
  assign push        = bus.pix_valid && pix_ready;
  assign commit      = mem_we_q && !bus.mem_wait;
  assign reg_free    = !mem_we_q || !bus.mem_wait;
  assign pop         = (state_q == StWrite) && !fifo_empty && reg_free;
  assign last_commit = commit && (mem_addr_q == LastAddr);

  pix_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (fifo_clr),
    .push_i  (push),
    .wdata_i (bus.pix_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // wr_addr_q tracks the address for the next pop; every pop is eventually committed in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      in_cnt_q     <= '0;
      wr_addr_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StWrite;
            in_cnt_q  <= '0;
            wr_addr_q <= '0;
          end
        end
        StWrite: begin
          if (push) in_cnt_q <= in_cnt_q + ADDR_W'(1);
          if (pop) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_addr_q;
            mem_wdata_q <= fifo_rdata;
            wr_addr_q   <= wr_addr_q + ADDR_W'(1);
          end else if (reg_free) begin
            mem_we_q <= 1'b0;
          end
          if (last_commit) begin
            state_q      <= StIdle;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = (state_q == StWrite);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_result_mem_writer.sv
// Scoreboard bench for result_mem_writer on a 4x2 frame: directed scenarios then random frames.
module tb_result_mem_writer;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned HEIGHT = 2;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int          PIX    = WIDTH * HEIGHT;
  localparam int          NRAND  = 20;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  result_mem_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  result_mem_writer #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];
  bit   model_active = 0;
  int   acc_cnt = 0;
  int   commit_cnt = 0;
  bit   fd_pend = 0;
  int   frames_seen = 0;
  int   first_acc_cyc = 0;
  int   first_we_cyc = 0;
  int   last_fd_cyc = 0;
  bit   saw_we = 0;
  bit   lat_chk = 0;
  bit   prev_stall = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: the k-th accepted pixel of a frame must land at address k.
  always @(negedge clk) begin
    bit   was_active;
    exp_t e;
    cyc++;
    if (rst) begin
      check("rst_pix_ready", bus.pix_ready, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_done", bus.frame_done, 0);
      sb.delete();
      model_active = 0;
      acc_cnt      = 0;
      commit_cnt   = 0;
      fd_pend      = 0;
      prev_stall   = 0;
    end else begin
      was_active = model_active;
      if (fd_pend || bus.frame_done) begin
        check("frame_done", bus.frame_done, fd_pend);
        if (fd_pend) check("busy_at_done", bus.busy, 0);
      end
      if (bus.frame_done) begin
        frames_seen++;
        last_fd_cyc = cyc;
      end
      fd_pend = 0;
      check("busy", bus.busy, was_active);
      if (!was_active || acc_cnt >= PIX) check("pix_ready_guard", bus.pix_ready, 0);
      if (prev_stall) begin
        check("hold_we", bus.mem_we, 1);
        check("hold_addr", bus.mem_addr, prev_addr);
        check("hold_data", bus.mem_wdata, prev_data);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (acc_cnt == 0) first_acc_cyc = cyc;
        e.addr = ADDR_W'(acc_cnt);
        e.data = bus.pix_data;
        sb.push_back(e);
        acc_cnt++;
      end
      if (bus.mem_we && !saw_we) begin
        saw_we       = 1;
        first_we_cyc = cyc;
        if (lat_chk) check("latency", cyc - first_acc_cyc, 2);
      end
      if (bus.mem_we && !bus.mem_wait) begin
        if (sb.size() == 0) begin
          check("unexpected_write_addr", bus.mem_addr, -1);
        end else begin
          e = sb.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", bus.mem_wdata, e.data);
          commit_cnt++;
          if (e.addr == ADDR_W'(PIX - 1)) begin
            check("frame_commits", commit_cnt, PIX);
            check("frame_accepts", acc_cnt, PIX);
            fd_pend      = 1;
            model_active = 0;
          end
        end
      end
      prev_stall = bus.mem_we && bus.mem_wait;
      prev_addr  = bus.mem_addr;
      prev_data  = bus.mem_wdata;
      if (bus.start && !was_active) begin
        model_active = 1;
        acc_cnt      = 0;
        commit_cnt   = 0;
        saw_we       = 0;
      end
    end
  end

  task automatic step(input bit st, input int pv, input int mw, input bit dir);
    @(posedge clk);
    #1;
    bus.start     = st;
    bus.pix_valid = ($urandom_range(99) < pv);
    bus.mem_wait  = ($urandom_range(99) < mw);
    bus.pix_data  = dir ? 8'(8'h10 + acc_cnt) : 8'($urandom);
  endtask

  task automatic wait_done(input int f0, input int budget, input int pv, input int mw,
                           input bit dir);
    for (int i = 0; i < budget && frames_seen == f0; i++) step(0, pv, mw, dir);
    check("frame_done_seen", frames_seen - f0, 1);
  endtask

  initial begin
    int f0;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.mem_wait  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame with latency and throughput.
    lat_chk = 1;
    f0 = frames_seen;
    step(1, 100, 0, 1);
    wait_done(f0, 100, 100, 0, 1);
    check("throughput", last_fd_cyc - first_we_cyc, PIX);
    lat_chk = 0;
    repeat (3) step(0, 0, 0, 1);

    // Backpressure: stall the memory for 10 cycles after two commits.
    f0 = frames_seen;
    step(1, 100, 0, 1);
    for (int i = 0; i < 50 && commit_cnt < 2; i++) step(0, 100, 0, 1);
    repeat (10) step(0, 100, 100, 1);
    @(negedge clk);
    #1;
    check("stall_in_flight", sb.size(), DEPTH + 1);
    check("stall_pix_ready", bus.pix_ready, 0);
    wait_done(f0, 100, 100, 0, 1);
    repeat (3) step(0, 0, 0, 1);

    // Overrun: offer 12 pixels, only 8 may go in.
    f0 = frames_seen;
    step(1, 0, 0, 1);
    repeat (12) step(0, 100, 0, 1);
    wait_done(f0, 100, 100, 0, 1);
    check("overrun_accepts", acc_cnt, PIX);
    repeat (4) step(0, 100, 0, 1);

    // Mid-frame start is ignored; reset after 3 commits aborts the frame.
    f0 = frames_seen;
    step(1, 100, 0, 1);
    for (int i = 0; i < 50 && commit_cnt < 3; i++) step(i == 1, 100, 0, 1);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step(0, 100, 0, 1);
    check("no_done_after_rst", frames_seen, f0);
    step(1, 100, 0, 1);
    wait_done(f0, 100, 100, 0, 1);

    // Random valid, stall and data.
    for (int f = 0; f < NRAND; f++) begin
      int pv;
      int mw;
      pv = $urandom_range(90, 30);
      mw = $urandom_range(60);
      repeat ($urandom_range(3)) step(0, 50, 50, 0);
      f0 = frames_seen;
      step(1, pv, mw, 0);
      wait_done(f0, 2000, pv, mw, 0);
    end
    repeat (3) step(0, 0, 0, 0);

    check("total_frames", frames_seen, 4 + NRAND);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
